// File: rtl/idft_wb_stream_bridge.sv
// Wishbone-to-stream bridge for the IDFT tile: CPU writes samples into an
// input FIFO that feeds the core, and reads core results back out of an output
// FIFO. Registered single-cycle Wishbone responses, level interrupt on
// output data available.

`timescale 1ns/1ps

// Synchronous FIFO with a flush that overrides any same-cycle push or pop.
module idft_wb_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [31:0]                data_i,
  input  logic                       pop_i,
  output logic [31:0]                data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [$clog2(DEPTH):0]     count_next_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Next pointers and count; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + AW'(1);
      if (pop_i)  rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage write.
  // NOTE: the data array has no reset; entries are only visible once the count covers them.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q] <= data_i;
  end

  assign data_o       = mem_q[rd_q];
  assign count_o      = cnt_q;
  assign count_next_o = cnt_d;
  assign full_o       = (cnt_q == CW'(DEPTH));
  assign empty_o      = (cnt_q == '0);
endmodule

module idft_wb_stream_bridge #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic [31:0] s_out_data,
  output logic        s_out_valid,
  input  logic        s_out_ready,
  input  logic [31:0] m_in_data,
  input  logic        m_in_valid,
  output logic        m_in_ready,
  output logic        irq
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [2:0] {
    REG_DATA_IN  = 3'd0,
    REG_DATA_OUT = 3'd1,
    REG_STATUS   = 3'd2,
    REG_CTRL     = 3'd3
  } reg_idx_e;

  logic          ack_q, ack_d, err_q, err_d, irq_q, irq_d;
  logic          irq_en_q, irq_en_d, rdy_en_q;
  logic [31:0]   dat_q, dat_d, status;
  logic          req, bad, flush, ctrl_wr;
  logic          in_push, in_pop, in_full, in_empty;
  logic          out_push, out_pop, out_full, out_empty;
  logic [31:0]   out_head;
  logic [CW-1:0] in_cnt, in_cnt_next, out_cnt, out_cnt_next;
  logic [2:0]    idx;
  logic          unused_bits;

  assign idx         = wb_adr_i[4:2];
  assign unused_bits = ^{wb_adr_i[31:5], wb_adr_i[1:0], in_cnt_next};

  // A new request is one not already being answered this cycle.
  assign req = wb_cyc_i && wb_stb_i && !(ack_q || err_q);

  assign status = {9'b0, 7'(out_cnt), 1'b0, 7'(in_cnt), 4'b0,
                   out_empty, out_full, in_empty, in_full};

  // Decode the request, classify it as ack or err, and form the read data.
  always_comb begin
    bad = (wb_sel_i != 4'hF) || idx[2]
       || (wb_we_i  && (idx == REG_DATA_OUT || idx == REG_STATUS))
       || (wb_we_i  && idx == REG_DATA_IN  && in_full)
       || (!wb_we_i && idx == REG_DATA_OUT && out_empty);
    ack_d   = req && !bad;
    err_d   = req && bad;
    ctrl_wr = ack_d && wb_we_i && idx == REG_CTRL;
    flush   = ctrl_wr && wb_dat_i[0];
    in_push = ack_d && wb_we_i && idx == REG_DATA_IN;
    out_pop = ack_d && !wb_we_i && idx == REG_DATA_OUT;
    irq_en_d = ctrl_wr ? wb_dat_i[1] : irq_en_q;
    dat_d = '0;
    if (ack_d && !wb_we_i) begin
      case (idx)
        REG_DATA_OUT: dat_d = out_head;
        REG_STATUS:   dat_d = status;
        REG_CTRL:     dat_d = {30'b0, irq_en_q, 1'b0};
        default:      dat_d = '0;
      endcase
    end
    irq_d = irq_en_d && (out_cnt_next != '0);
  end

  assign in_pop   = s_out_valid && s_out_ready;
  assign out_push = m_in_valid && m_in_ready;

  // Response, control and interrupt registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      dat_q    <= '0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      ack_q    <= ack_d;
      err_q    <= err_d;
      dat_q    <= dat_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
      rdy_en_q <= 1'b1;
    end
  end

  idft_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_in_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush),
    .push_i       (in_push),
    .data_i       (wb_dat_i),
    .pop_i        (in_pop),
    .data_o       (s_out_data),
    .count_o      (in_cnt),
    .count_next_o (in_cnt_next),
    .full_o       (in_full),
    .empty_o      (in_empty)
  );

  idft_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_out_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush),
    .push_i       (out_push),
    .data_i       (m_in_data),
    .pop_i        (out_pop),
    .data_o       (out_head),
    .count_o      (out_cnt),
    .count_next_o (out_cnt_next),
    .full_o       (out_full),
    .empty_o      (out_empty)
  );

  assign wb_ack_o    = ack_q;
  assign wb_err_o    = err_q;
  assign wb_dat_o    = dat_q;
  assign irq         = irq_q;
  assign s_out_valid = !in_empty;
  // Ready is held low through reset and until the first clock after release.
  assign m_in_ready  = rdy_en_q && !out_full;
endmodule

// File: tb/tb_idft_wb_stream_bridge.sv
// Self-checking bench for idft_wb_stream_bridge: a table of register accesses
// plus hand-written sequences for full/empty, interrupt, flush and reset.

`timescale 1ns/1ps

module tb_idft_wb_stream_bridge;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] wb_adr_i = '0, wb_dat_i = '0;
  logic [3:0]  wb_sel_i = '0;
  logic        wb_we_i = 1'b0, wb_cyc_i = 1'b0, wb_stb_i = 1'b0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, wb_err_o;
  logic [31:0] s_out_data;
  logic        s_out_valid;
  logic        s_out_ready = 1'b0;
  logic [31:0] m_in_data = '0;
  logic        m_in_valid = 1'b0;
  logic        m_in_ready;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;
  int hs_cnt   = 0;
  logic [31:0] in_q[$];
  logic [31:0] out_q[$];

  typedef struct {
    logic        we;
    logic [2:0]  idx;
    logic [3:0]  sel;
    logic [31:0] d;
    logic        exp_err;
    logic [31:0] exp_dat;
  } vec_t;
  vec_t vecs[16];

  idft_wb_stream_bridge #(.FIFO_DEPTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb_adr_i   (wb_adr_i),
    .wb_dat_i   (wb_dat_i),
    .wb_sel_i   (wb_sel_i),
    .wb_we_i    (wb_we_i),
    .wb_cyc_i   (wb_cyc_i),
    .wb_stb_i   (wb_stb_i),
    .wb_dat_o   (wb_dat_o),
    .wb_ack_o   (wb_ack_o),
    .wb_err_o   (wb_err_o),
    .s_out_data (s_out_data),
    .s_out_valid(s_out_valid),
    .s_out_ready(s_out_ready),
    .m_in_data  (m_in_data),
    .m_in_valid (m_in_valid),
    .m_in_ready (m_in_ready),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input logic [31:0] act);
    n_checks++;
    n_errors++;
    $display("FAIL %s actual=0x%08h required=none", name, act);
  endtask

  // Stream scoreboards, sampled on the falling edge ahead of the handshake edge.
  always @(negedge clk) begin
    if (rst_n && s_out_valid && s_out_ready) begin
      hs_cnt++;
      if (in_q.size() == 0) fail("s_out_extra", s_out_data);
      else check("s_out_data", s_out_data, in_q.pop_front());
    end
    if (rst_n && m_in_valid && m_in_ready) out_q.push_back(m_in_data);
  end

  // One Wishbone access; called and returns at posedge+1.
  task automatic do_wb(input string name, input logic we, input logic [2:0] idx,
                       input logic [3:0] sel, input logic [31:0] d,
                       input logic exp_err, input logic [31:0] exp_dat, input logic chk_dat);
    logic ack, err;
    logic [31:0] rd;
    int lat;
    ack = 1'b0; err = 1'b0; rd = '0; lat = -1;
    wb_adr_i = {24'hC0FFEE, 3'b101, idx, 2'b11};
    wb_dat_i = d; wb_sel_i = sel; wb_we_i = we;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      if (wb_ack_o || wb_err_o) begin
        lat = n; ack = wb_ack_o; err = wb_err_o; rd = wb_dat_o;
        break;
      end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    if (lat < 0) fail({name, "_timeout"}, 32'h0);
    else begin
      check({name, "_lat"}, 32'(lat), 32'h0);
      check({name, "_resp"}, {30'b0, ack, err}, exp_err ? 32'h1 : 32'h2);
      if (exp_err) check({name, "_errdat"}, rd, 32'h0);
      else if (chk_dat) check({name, "_dat"}, rd, exp_dat);
    end
    @(posedge clk); #1;
    check({name, "_pulse"}, {30'b0, wb_ack_o, wb_err_o}, 32'h0);
  endtask

  task automatic wr_in(input string name, input logic [31:0] d, input logic exp_err);
    if (!exp_err) in_q.push_back(d);
    do_wb(name, 1'b1, 3'd0, 4'hF, d, exp_err, 32'h0, 1'b0);
  endtask

  task automatic rd_out(input string name);
    logic [31:0] exp;
    logic e;
    e = (out_q.size() == 0);
    exp = e ? 32'h0 : out_q.pop_front();
    do_wb(name, 1'b0, 3'd1, 4'hF, 32'h0, e, exp, 1'b1);
  endtask

  task automatic rd_status(input string name, input logic [31:0] exp);
    do_wb(name, 1'b0, 3'd2, 4'hF, 32'h0, 1'b0, exp, 1'b1);
  endtask

  task automatic wr_ctrl(input string name, input logic [31:0] d);
    do_wb(name, 1'b1, 3'd3, 4'hF, d, 1'b0, 32'h0, 1'b0);
  endtask

  // Core-side push; called and returns at posedge+1.
  task automatic core_push(input logic [31:0] d);
    logic done;
    done = 1'b0;
    m_in_data = d; m_in_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (m_in_ready) begin done = 1'b1; break; end
    end
    @(posedge clk); #1;
    m_in_valid = 1'b0;
    if (!done) fail("core_push_timeout", d);
  endtask

  initial begin
    //           we    idx   sel   data          err   rdata
    vecs[0]  = '{1'b0, 3'd2, 4'hF, 32'h0,        1'b0, 32'h0000_000A};
    vecs[1]  = '{1'b1, 3'd0, 4'hF, 32'h11,       1'b0, 32'h0};
    vecs[2]  = '{1'b1, 3'd0, 4'hF, 32'h22,       1'b0, 32'h0};
    vecs[3]  = '{1'b1, 3'd0, 4'hF, 32'h33,       1'b0, 32'h0};
    vecs[4]  = '{1'b0, 3'd2, 4'hF, 32'h0,        1'b0, 32'h0000_0308};
    vecs[5]  = '{1'b1, 3'd2, 4'hF, 32'h5,        1'b1, 32'h0};
    vecs[6]  = '{1'b1, 3'd1, 4'hF, 32'h6,        1'b1, 32'h0};
    vecs[7]  = '{1'b0, 3'd1, 4'hF, 32'h0,        1'b1, 32'h0};
    vecs[8]  = '{1'b0, 3'd5, 4'hF, 32'h0,        1'b1, 32'h0};
    vecs[9]  = '{1'b1, 3'd0, 4'h3, 32'h44,       1'b1, 32'h0};
    vecs[10] = '{1'b1, 3'd3, 4'hF, 32'h2,        1'b0, 32'h0};
    vecs[11] = '{1'b0, 3'd3, 4'hF, 32'h0,        1'b0, 32'h2};
    vecs[12] = '{1'b1, 3'd3, 4'hF, 32'h0,        1'b0, 32'h0};
    vecs[13] = '{1'b0, 3'd3, 4'hF, 32'h0,        1'b0, 32'h0};
    vecs[14] = '{1'b0, 3'd2, 4'hF, 32'h0,        1'b0, 32'h0000_0308};
    vecs[15] = '{1'b1, 3'd7, 4'hF, 32'h77,       1'b1, 32'h0};

    // Reset values while rst_n is low.
    #12;
    check("rst_outs", {26'b0, wb_ack_o, wb_err_o, s_out_valid, m_in_ready, irq, 1'b0}, 32'h0);
    check("rst_dat", wb_dat_o, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Register table; stream sink held off so DATA_IN entries stay queued.
    foreach (vecs[i]) begin
      if (vecs[i].we && vecs[i].idx == 3'd0 && !vecs[i].exp_err) in_q.push_back(vecs[i].d);
      do_wb($sformatf("vec%0d", i), vecs[i].we, vecs[i].idx, vecs[i].sel, vecs[i].d,
            vecs[i].exp_err, vecs[i].exp_dat, !vecs[i].we);
    end
    check("hold_valid", 32'(s_out_valid), 32'h1);
    check("hold_data", s_out_data, 32'h11);
    check("irq_idle", 32'(irq), 32'h0);

    // Drain three samples on consecutive cycles.
    hs_cnt = 0;
    s_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("drain3_hs", 32'(hs_cnt), 32'h3);
    check("drain3_empty", 32'(s_out_valid), 32'h0);
    s_out_ready = 1'b0;
    rd_status("st_drained", 32'h0000_000A);

    // Input FIFO full: ninth write is refused and never reaches the stream.
    for (int i = 0; i < 8; i++) wr_in($sformatf("fill%0d", i), 32'h200 + 32'(i), 1'b0);
    wr_in("overflow", 32'hDEAD, 1'b1);
    rd_status("st_infull", 32'h0000_0809);
    check("full_head", s_out_data, 32'h200);
    hs_cnt = 0;
    s_out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    s_out_ready = 1'b0;
    check("full_drain_hs", 32'(hs_cnt), 32'h8);
    check("full_drain_q", 32'(in_q.size()), 32'h0);

    // Interrupt follows output-FIFO occupancy when enabled.
    wr_ctrl("irq_en", 32'h2);
    check("irq_empty", 32'(irq), 32'h0);
    core_push(32'hA5A5);
    check("irq_set", 32'(irq), 32'h1);
    rd_out("rd_a5a5");
    check("irq_clr", 32'(irq), 32'h0);
    rd_out("rd_empty");
    wr_ctrl("irq_dis", 32'h0);

    // Output FIFO full, then pop and push in the same cycle.
    for (int i = 0; i < 8; i++) core_push(32'h100 + 32'(i));
    check("out_full_rdy", 32'(m_in_ready), 32'h0);
    rd_status("st_outfull", 32'h0008_0006);
    m_in_data = 32'h108; m_in_valid = 1'b1;
    wb_adr_i = 32'h4; wb_sel_i = 4'hF; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge clk); #1;
    check("sim_ack", {30'b0, wb_ack_o, wb_err_o}, 32'h2);
    check("sim_dat", wb_dat_o, out_q.size() > 0 ? out_q.pop_front() : 32'hDEAD_BEEF);
    check("sim_rdy", 32'(m_in_ready), 32'h1);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(posedge clk); #1;
    m_in_valid = 1'b0;
    check("sim_refull", 32'(m_in_ready), 32'h0);
    rd_status("st_refull", 32'h0008_0006);
    for (int i = 0; i < 8; i++) rd_out($sformatf("drain%0d", i));
    rd_status("st_outdrained", 32'h0000_000A);

    // Flush with both FIFOs occupied and a stream handshake in the same cycle.
    for (int i = 0; i < 5; i++) wr_in($sformatf("pf_in%0d", i), 32'h400 + 32'(i), 1'b0);
    for (int i = 0; i < 3; i++) core_push(32'h500 + 32'(i));
    rd_status("st_preflush", 32'h0003_0500);
    s_out_ready = 1'b1;
    wr_ctrl("flush", 32'h1);
    s_out_ready = 1'b0;
    in_q.delete();
    out_q.delete();
    rd_status("st_flushed", 32'h0000_000A);
    rd_out("rd_after_flush");

    // Reset in the middle of a DATA_IN write with four entries queued.
    for (int i = 0; i < 4; i++) wr_in($sformatf("pr_in%0d", i), 32'h300 + 32'(i), 1'b0);
    wb_adr_i = 32'h0; wb_dat_i = 32'h3FF; wb_sel_i = 4'hF; wb_we_i = 1'b1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    in_q.delete();
    out_q.delete();
    check("mid_rst_outs", {26'b0, wb_ack_o, wb_err_o, s_out_valid, m_in_ready, irq, 1'b0}, 32'h0);
    check("mid_rst_dat", wb_dat_o, 32'h0);
    @(posedge clk); #1;
    check("mid_rst_noack", {30'b0, wb_ack_o, wb_err_o}, 32'h0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    rd_status("st_post_rst", 32'h0000_000A);
    check("post_rst_valid", 32'(s_out_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
